liteic_rr_arbiter: RTL and testbench
====================================

Name: liteic_rr_arbiter

Overview:
Round-robin arbiter with transaction lock that shares one interconnect slave port between NUM_MASTERS master slots of the lite interconnect. It picks one requester, holds the grant until the granted master's transaction completes or a watchdog expires, then rotates priority. Outputs drive the slave-side request/response mux select as one-hot and binary index.

Parameters:
NUM_MASTERS, 4, number of requesting master slots; legal range 2..32.
IDX_W, $clog2(NUM_MASTERS), width of the binary grant index.
TIMEOUT_CYCLES, 256, maximum grant hold in cycles before forced release; 0 disables the watchdog.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rstn_i  input  1  reset; asynchronous assert, active-low.
req_i  input  NUM_MASTERS  per-master request; bit i high = master i wants the slave.
done_i  input  1  end of transaction on the granted path (final response handshake); sampled only while grant_valid_o=1.
grant_valid_o  output  1  a grant is active.
grant_onehot_o  output  NUM_MASTERS  one-hot grant; all zero when grant_valid_o=0.
grant_idx_o  output  IDX_W  binary index of the granted master; 0 when grant_valid_o=0.
timeout_o  output  1  single-cycle pulse on forced release.
timeout_idx_o  output  IDX_W  index of the master released by the watchdog; held until the next timeout.

Behaviour:
- Reset (rstn_i low, asynchronous): state IDLE; grant_valid_o=0; grant_onehot_o=0; grant_idx_o=0; timeout_o=0; timeout_idx_o=0; hold counter=0; priority pointer ptr=NUM_MASTERS-1, so master 0 has highest priority after reset.
- All outputs are registered. There is no combinational path from req_i or done_i to the outputs.
- Arbitration function: search order is ptr+1, ptr+2, ... (wrapping modulo NUM_MASTERS) through ptr. The first index with req_i set wins. The pointer itself has lowest priority.
- State IDLE:
  - If req_i is nonzero, the grant for the winner appears on the next edge. Latency is 1 cycle from req_i to grant_valid_o.
  - On grant: state becomes GRANT, ptr is set to the winner's index, and the counter is cleared.
- State GRANT (lock):
  - Changes on req_i, including the granted master deasserting its request, are ignored. The grant holds.
  - The counter increments each cycle while done_i=0.
- Release on done_i=1 in GRANT:
  - If any req_i bit is set in the same cycle, re-arbitrate from the updated ptr. The new grant is registered on the next edge with no idle cycle (back-to-back).
  - The just-finished master competes at lowest priority.
  - If req_i=0, return to IDLE and drop grant_valid_o on the next edge.
- Watchdog: when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with done_i=0:
  - Release exactly as for done_i.
  - Pulse timeout_o for 1 cycle, coincident with the edge where the grant changes.
  - Load timeout_idx_o with the released index.
- Watchdog boundaries:
  - done_i and timeout in the same cycle: done_i wins and there is no timeout pulse.
  - TIMEOUT_CYCLES=1: the watchdog fires on the first GRANT cycle without done_i.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Invariants:
  - grant_onehot_o has at most one bit set.
  - grant_onehot_o[grant_idx_o]==grant_valid_o.
  - A master with continuous req_i is granted within NUM_MASTERS-1 other grants (fairness bound).
- Reset mid-GRANT: outputs clear immediately (asynchronously); after release the first grant again favours master 0.

Test Plan:
1. Reset and single request: hold rstn_i low, then release; check all outputs 0. Drive req_i=4'b0100; next edge gives grant_valid_o=1, grant_onehot_o=4'b0100, grant_idx_o=2.
2. Round-robin fairness: after reset, hold req_i=4'b1111 and pulse done_i once per grant. Grants must be idx 0,1,2,3,0 with no idle cycle between them.
3. Lock: grant idx 1 active; change req_i to 4'b1101 (master 1 drops, others raise) for 10 cycles with done_i=0. grant_idx_o must stay 1 throughout.
4. Watchdog: TIMEOUT_CYCLES=8, req_i=4'b0011, never assert done_i. Expect grant 0 for exactly 8 cycles, then timeout_o pulse with timeout_idx_o=0, then grant moves to idx 1.
5. Done and timeout in the same cycle: assert done_i on cycle 8 of the grant (TIMEOUT_CYCLES=8). Grant is released and timeout_o stays 0.
6. Reset mid-grant: grant idx 3 active; pulse rstn_i low for a half cycle. Outputs must clear without waiting for an edge; with req_i=4'b1010 held, the next grant is idx 1.

Source files
------------

// File: rtl/liteic_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// liteic_rr_arbiter_if
// Request/grant bundle between the master slots of the lite interconnect and
// the round-robin arbiter that owns the shared slave port.
//
//   req_i          per-master request, bit i = master i wants the slave
//   done_i         final response handshake on the currently granted path
//   grant_valid_o  a grant is active
//   grant_onehot_o one-hot mux select for the slave-side request/response mux
//   grant_idx_o    binary index of the granted master (0 when idle)
//   timeout_o      single-cycle pulse when the watchdog forces a release
//   timeout_idx_o  index of the master last released by the watchdog
//
// Modports: master = requester side, slave = arbiter side.
// NUM_MASTERS / IDX_W must match the parameters of the arbiter instance.
// ---------------------------------------------------------------------------
interface liteic_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] req_i;
    logic                   done_i;
    logic                   grant_valid_o;
    logic [NUM_MASTERS-1:0] grant_onehot_o;
    logic [IDX_W-1:0]       grant_idx_o;
    logic                   timeout_o;
    logic [IDX_W-1:0]       timeout_idx_o;

    modport master (
        output req_i,
        output done_i,
        input  grant_valid_o,
        input  grant_onehot_o,
        input  grant_idx_o,
        input  timeout_o,
        input  timeout_idx_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output grant_valid_o,
        output grant_onehot_o,
        output grant_idx_o,
        output timeout_o,
        output timeout_idx_o
    );
endinterface

// File: rtl/liteic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// liteic_rr_arbiter
// Round-robin arbiter with transaction lock for one shared slave port.
// A grant is held until the owner signals done_i or the hold watchdog
// expires; priority then rotates so the finished master ranks lowest.
// All outputs are registered (no combinational path from req_i/done_i).
//
// Ports:
//   clk_i   clock, rising edge
//   rstn_i  asynchronous active-low reset
//   arb     liteic_rr_arbiter_if.slave (req/done in, grant/timeout out)
//
// Parameters:
//   NUM_MASTERS     requesting slots, 2..32
//   IDX_W           width of the binary grant index
//   TIMEOUT_CYCLES  max grant hold in cycles, 0 disables the watchdog
// ---------------------------------------------------------------------------
module liteic_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int IDX_W          = $clog2(NUM_MASTERS),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    liteic_rr_arbiter_if.slave  arb
);

    // A disabled watchdog still needs a legal (1-bit) counter vector.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   gv_q, gv_d;
    logic [NUM_MASTERS-1:0] oh_q, oh_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   to_q, to_d;
    logic [IDX_W-1:0]       toidx_q, toidx_d;

    logic [IDX_W-1:0]       win;
    logic                   any_req;
    logic                   wd_hit;

    // Winner searching ptr+1, ptr+2, ... ptr. The loop runs from the far end
    // back towards ptr+1 so the nearest requester is the last assignment.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_W-1:0]       p
    );
        logic [IDX_W-1:0] sel;
        int               k;
        sel = p;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            k = (int'(p) + i) % NUM_MASTERS;
            if (req[IDX_W'(k)]) begin
                sel = IDX_W'(k);
            end
        end
        return sel;
    endfunction

    assign any_req = |arb.req_i;
    // While granted, ptr_q equals the owner, so the same search puts the
    // finishing master last when re-arbitrating back-to-back.
    assign win     = rr_pick(arb.req_i, ptr_q);
    assign wd_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gv_d    = gv_q;
        oh_d    = oh_q;
        idx_d   = idx_q;
        to_d    = 1'b0;
        toidx_d = toidx_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    ptr_d   = win;
                    cnt_d   = '0;
                    gv_d    = 1'b1;
                    oh_d    = NUM_MASTERS'(1) << win;
                    idx_d   = win;
                end
            end
            GRANT: begin
                if (arb.done_i || wd_hit) begin
                    // done_i has precedence: a completed transaction is
                    // never reported as a timeout.
                    if (!arb.done_i) begin
                        to_d    = 1'b1;
                        toidx_d = idx_q;
                    end
                    cnt_d = '0;
                    if (any_req) begin
                        ptr_d = win;
                        gv_d  = 1'b1;
                        oh_d  = NUM_MASTERS'(1) << win;
                        idx_d = win;
                    end else begin
                        state_d = IDLE;
                        gv_d    = 1'b0;
                        oh_d    = '0;
                        idx_d   = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            gv_q    <= 1'b0;
            oh_q    <= '0;
            idx_q   <= '0;
            to_q    <= 1'b0;
            toidx_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gv_q    <= gv_d;
            oh_q    <= oh_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
            toidx_q <= toidx_d;
        end
    end

    assign arb.grant_valid_o  = gv_q;
    assign arb.grant_onehot_o = oh_q;
    assign arb.grant_idx_o    = idx_q;
    assign arb.timeout_o      = to_q;
    assign arb.timeout_idx_o  = toidx_q;

endmodule

// File: tb/tb_liteic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_liteic_rr_arbiter
// Two arbiter instances share the same req/done stimulus: one with the
// default 256-cycle watchdog, one with an 8-cycle watchdog. A reference
// model predicts the registered outputs after each edge and queues them;
// a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_liteic_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] req  = '0;
    logic         done = 1'b0;

    always #5 clk = ~clk;

    liteic_rr_arbiter_if #(.NUM_MASTERS(N), .IDX_W(IW)) bus0 ();
    liteic_rr_arbiter_if #(.NUM_MASTERS(N), .IDX_W(IW)) bus1 ();

    assign bus0.req_i  = req;
    assign bus0.done_i = done;
    assign bus1.req_i  = req;
    assign bus1.done_i = done;

    liteic_rr_arbiter #(.NUM_MASTERS(N), .IDX_W(IW), .TIMEOUT_CYCLES(256)) dut0 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .arb    (bus0)
    );

    liteic_rr_arbiter #(.NUM_MASTERS(N), .IDX_W(IW), .TIMEOUT_CYCLES(8)) dut1 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .arb    (bus1)
    );

    typedef struct packed {
        logic          gv;
        logic [N-1:0]  oh;
        logic [IW-1:0] idx;
        logic          to;
        logic [IW-1:0] toidx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance: owner of the slave (-1 = none),
    // lowest-priority master, cycles already spent in the current grant.
    int to_cfg [2] = '{256, 8};
    int m_owner[2];
    int m_ptr  [2];
    int m_held [2];
    int m_toidx[2];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_ptr[d]   = N - 1;
            m_held[d]  = 0;
            m_toidx[d] = 0;
        end
    endtask

    // First requester in the order p+1, p+2, ... p (modulo N).
    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            if (r[2'((p + i) % N)]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input int d, output exp_t e);
        bit rel;
        rel  = 1'b0;
        e.to = 1'b0;
        if (m_owner[d] < 0) begin
            if (req != 0) begin
                m_owner[d] = pick(m_ptr[d], req);
                m_ptr[d]   = m_owner[d];
                m_held[d]  = 0;
            end
        end else begin
            if (done) begin
                rel = 1'b1;
            end else if (to_cfg[d] != 0 && m_held[d] + 1 >= to_cfg[d]) begin
                rel        = 1'b1;
                e.to       = 1'b1;
                m_toidx[d] = m_owner[d];
            end else begin
                m_held[d]++;
            end
            if (rel) begin
                m_held[d] = 0;
                if (req != 0) begin
                    m_owner[d] = pick(m_owner[d], req);
                    m_ptr[d]   = m_owner[d];
                end else begin
                    m_owner[d] = -1;
                end
            end
        end
        e.gv    = (m_owner[d] >= 0);
        e.oh    = e.gv ? (N'(1) << m_owner[d]) : '0;
        e.idx   = e.gv ? IW'(m_owner[d]) : '0;
        e.toidx = IW'(m_toidx[d]);
    endtask

    // Apply inputs for one edge; expectations are queued after the edge so
    // the following falling edge is the one that checks them.
    task automatic step(input logic [N-1:0] r, input logic dn);
        exp_t e0, e1;
        req  = r;
        done = dn;
        model_edge(0, e0);
        model_edge(1, e1);
        @(posedge clk);
        q0.push_back(e0);
        q1.push_back(e1);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_d0_gv"},    int'(bus0.grant_valid_o),  0);
        chk({tag, "_d0_oh"},    int'(bus0.grant_onehot_o), 0);
        chk({tag, "_d0_idx"},   int'(bus0.grant_idx_o),    0);
        chk({tag, "_d0_to"},    int'(bus0.timeout_o),      0);
        chk({tag, "_d0_toidx"}, int'(bus0.timeout_idx_o),  0);
        chk({tag, "_d1_gv"},    int'(bus1.grant_valid_o),  0);
        chk({tag, "_d1_oh"},    int'(bus1.grant_onehot_o), 0);
        chk({tag, "_d1_idx"},   int'(bus1.grant_idx_o),    0);
        chk({tag, "_d1_to"},    int'(bus1.timeout_o),      0);
        chk({tag, "_d1_toidx"}, int'(bus1.timeout_idx_o),  0);
    endtask

    // Reset pulse entirely between two rising edges; outputs must clear
    // before any edge arrives.
    task automatic do_reset();
        @(negedge clk);
        #1 rstn = 1'b0;
        #1 check_idle_outputs("async_rst");
        model_reset();
        #1 rstn = 1'b1;
    endtask

    task automatic cmp(input int d, input exp_t e);
        logic          gv, to;
        logic [N-1:0]  oh;
        logic [IW-1:0] idx, toidx;
        if (d == 0) begin
            gv = bus0.grant_valid_o; oh = bus0.grant_onehot_o; idx = bus0.grant_idx_o;
            to = bus0.timeout_o;     toidx = bus0.timeout_idx_o;
        end else begin
            gv = bus1.grant_valid_o; oh = bus1.grant_onehot_o; idx = bus1.grant_idx_o;
            to = bus1.timeout_o;     toidx = bus1.timeout_idx_o;
        end
        chk($sformatf("d%0d_grant_valid", d),  int'(gv),    int'(e.gv));
        chk($sformatf("d%0d_grant_onehot", d), int'(oh),    int'(e.oh));
        chk($sformatf("d%0d_grant_idx", d),    int'(idx),   int'(e.idx));
        chk($sformatf("d%0d_timeout", d),      int'(to),    int'(e.to));
        chk($sformatf("d%0d_timeout_idx", d),  int'(toidx), int'(e.toidx));
        chk($sformatf("d%0d_onehot_atmost1", d), int'($countones(oh) <= 1), 1);
        chk($sformatf("d%0d_onehot_at_idx", d),  int'(oh[idx]), int'(gv));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp(0, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp(1, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        // Reset state, then a single request from master 2
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("rst");
        rstn = 1'b1;
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Round-robin with all requesting: 0,1,2,3,0 back-to-back
        do_reset();
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Lock: master 1 owns the slave while requests change under it
        do_reset();
        step(4'b0010, 1'b0);
        repeat (10) step(4'b1101, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Watchdog with no done at all
        do_reset();
        repeat (20) step(4'b0011, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // done on the same cycle the 8-cycle watchdog would fire
        do_reset();
        step(4'b0011, 1'b0);
        repeat (7) step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Reset while master 3 holds the grant, then 1010 -> master 1
        do_reset();
        step(4'b1000, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        do_reset();
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b0000, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
